neuron_feeder: RTL and testbench
================================

// Module: neuron_feeder
// PURPOSE
//  Sequencer that drives one neuron_v2-style MAC over its input interface: clk, rst, inptReady, w, x, b.
//  Holds a K-entry weight buffer, a K-entry input buffer and a bias register, all loaded by the host.
//  On start it clears the neuron, streams K (w,x) pairs on consecutive cycles, applies the bias once,
//  then captures the neuron's saturated Q-format output into a result register.
//  Sits between the layer controller/host and each neuron instance.
// PARAMETERS
//  N   10  data width, signed two's complement, shared with the neuron
//  Q   9   fractional bits, informational only; no arithmetic is done here
//  K   8   number of (w,x) pairs per evaluation, K>=1
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  w_we       in   1       write weight buffer entry w_addr
//  x_we       in   1       write input buffer entry w_addr (shared address)
//  b_we       in   1       write bias register
//  w_addr     in   AW      buffer index, AW=$clog2(K) (min 1); values >=K are ignored
//  wr_data    in   N       signed write data for w/x/b
//  start      in   1       begin an evaluation (single-cycle pulse)
//  busy       out  1       evaluation in progress
//  done       out  1       1-cycle pulse; result valid
//  result     out  N       captured neuron output; held until next capture
//  neu_rst    out  1       to neuron rst (active-high, synchronous at the neuron)
//  neu_inpt   out  1       to neuron inptReady
//  neu_w      out  N       to neuron w
//  neu_x      out  N       to neuron x
//  neu_b      out  N       to neuron b
//  neu_out    in   N       from neuron out
// BEHAVIOUR
//  Reset (rst=0, asynchronous): all buffers and the bias go to 0. FSM goes to IDLE.
//    busy=0, done=0, result=0, neu_rst=1, neu_inpt=0, neu_w=neu_x=neu_b=0.
//  FSM: IDLE -> CLEAR -> STREAM -> BIAS -> WAIT -> DONE -> IDLE. All outputs are registered.
//   IDLE : neu_rst=0. start=1 -> CLEAR. Writes are accepted only in IDLE and DONE.
//   CLEAR: neu_rst=1 for 1 cycle. busy=1 from this state through WAIT. Index i=0.
//   STREAM: K cycles. neu_inpt=1, neu_w=W[i], neu_x=X[i], i++. i==K-1 -> BIAS.
//   BIAS : neu_inpt=0, neu_b=bias for 1 cycle. neu_b=0 in every other state.
//          A zero bias is a legal no-op at the neuron.
//   WAIT : neu_out now reflects sum+bias. result<=neu_out at the end of this cycle.
//   DONE : done=1 for 1 cycle. busy=0. start here -> CLEAR (back-to-back); otherwise -> IDLE.
//  Latency: start sampled at edge t gives done=1 in cycle t+K+4. Throughput is 1 evaluation per K+4 cycles.
//  start while busy=1 is ignored (no queueing).
//  Writes while busy=1 are dropped. Buffer contents are stable for the whole evaluation.
//  Writes in the same cycle as an accepted start take effect. The evaluation uses the new values.
//  Arithmetic is done entirely in the neuron. This block does no width or format conversion.
//  The neuron adds b<<<N, so the bias contributes 2*b LSBs to the output.
//  Reset mid-evaluation: everything aborts immediately and no done pulse is produced.
//    neu_rst is held high while reset is active.
// CONFIGURATION
//  FEEDER_RELU_EN defined:
//    result <= (neu_out[N-1] ? 0 : neu_out), i.e. ReLU at capture. Latency is unchanged.
//  FEEDER_RELU_EN undefined:
//    result is the raw neu_out. The ReLU logic is not present.
// STRUCTURE
//  Shared package nar_pkg: state enum (IDLE, CLEAR, STREAM, BIAS, WAIT, DONE).
//    Also holds the N/Q defaults and the state encoding width.
//  Optional sub-module feeder_buf: K-deep, N-wide register file.
//    One write port and one async read port. Instantiated twice (W and X).
//  The FSM, index counter and capture logic stay in the top.
// TESTING (K=8, N=10, Q=9; bench instantiates neuron_v2 as the consumer)
//  1. All W=64, X=128, bias=0, start.
//     Expect neu_inpt high exactly 8 cycles, done at start+12, result=128.
//  2. All W=-64, X=128, bias=0.
//     Expect result=10'h380 (-128). With FEEDER_RELU_EN: result=0.
//  3. W=0, X=0, bias=32.
//     Expect result=64 (bias x2 scaling). neu_b=32 only in the BIAS cycle.
//  4. Pulse start at DONE with new W written in the same cycle.
//     Expect a back-to-back evaluation with no IDLE cycle; the second result uses the new W.
//  5. start and w_we while busy.
//     Expect both ignored: single done, buffers unchanged on readback via a re-run.
//  6. Assert rst during STREAM (i=3).
//     Expect busy=0, no done, neu_rst=1, result=0. A new run after release gives the correct value.

Source files
------------

// File: rtl/nar_pkg.sv
// nar_pkg: shared defaults and FSM state encoding for the neuron feeder
package nar_pkg;
  localparam int N_DEF = 10;
  localparam int Q_DEF = 9;
  localparam int SW = 3;
  typedef enum logic [SW-1:0] {IDLE, CLEAR, STREAM, BIAS, WAIT, DONE} state_t;
endpackage

// File: rtl/feeder_buf.sv
// feeder_buf: K-deep N-wide register file, one write port, one async read port
module feeder_buf #(
  parameter int N = 10,
  parameter int K = 8,
  parameter int AW = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic signed [N-1:0] wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic signed [N-1:0] rd_data
);
  logic signed [N-1:0] mem [K];
  // addresses at or beyond K match no entry, so those writes fall away
  always_ff @(posedge clk or negedge rst)
    if (!rst) mem <= '{default: '0};
    else for (int i = 0; i < K; i++) if (we && addr == AW'(i)) mem[i] <= wr_data;
  // async read feeds the registered stream outputs in the top
  always_comb rd_data = mem[rd_addr];
endmodule

// File: rtl/neuron_feeder.sv
// neuron_feeder: sequences K (w,x) pairs plus bias into a neuron MAC and captures its output; FEEDER_RELU_EN adds ReLU at capture
module neuron_feeder
  import nar_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = 8,
  localparam int AW = K > 1 ? $clog2(K) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_we,
  input  logic                x_we,
  input  logic                b_we,
  input  logic [AW-1:0]       w_addr,
  input  logic signed [N-1:0] wr_data,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic signed [N-1:0] result,
  output logic                neu_rst,
  output logic                neu_inpt,
  output logic signed [N-1:0] neu_w,
  output logic signed [N-1:0] neu_x,
  output logic signed [N-1:0] neu_b,
  input  logic signed [N-1:0] neu_out
);
  state_t state, nxt;
  logic [AW-1:0] idx, nidx;
  logic signed [N-1:0] bias, w_rd, x_rd;
  logic wr_ok;
  // host writes land only while no evaluation is using the buffers
  always_comb wr_ok = state == IDLE || state == DONE;
  // index of the pair presented in the coming cycle; restarts from 0 outside STREAM
  always_comb nidx = state == STREAM ? idx + 1'b1 : '0;
  // next-state: DONE may jump straight to CLEAR for back-to-back evaluations
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? CLEAR : IDLE;
      CLEAR:   nxt = STREAM;
      STREAM:  nxt = idx == AW'(K - 1) ? BIAS : STREAM;
      BIAS:    nxt = WAIT;
      WAIT:    nxt = DONE;
      DONE:    nxt = start ? CLEAR : IDLE;
      default: nxt = IDLE;
    endcase
  end
  feeder_buf #(.N(N), .K(K), .AW(AW)) u_wbuf (
    .clk(clk), .rst(rst), .we(w_we && wr_ok), .addr(w_addr), .wr_data(wr_data),
    .rd_addr(nidx), .rd_data(w_rd)
  );
  feeder_buf #(.N(N), .K(K), .AW(AW)) u_xbuf (
    .clk(clk), .rst(rst), .we(x_we && wr_ok), .addr(w_addr), .wr_data(wr_data),
    .rd_addr(nidx), .rd_data(x_rd)
  );
  // state, bias and all outputs registered from the next state so they align with it
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      bias     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      neu_rst  <= 1'b1;
      neu_inpt <= 1'b0;
      neu_w    <= '0;
      neu_x    <= '0;
      neu_b    <= '0;
    end else begin
      state    <= nxt;
      idx      <= nidx;
      if (b_we && wr_ok) bias <= wr_data;
      busy     <= nxt inside {CLEAR, STREAM, BIAS, WAIT};
      done     <= nxt == DONE;
      neu_rst  <= nxt == CLEAR;
      neu_inpt <= nxt == STREAM;
      neu_w    <= nxt == STREAM ? w_rd : '0;
      neu_x    <= nxt == STREAM ? x_rd : '0;
      neu_b    <= nxt == BIAS ? bias : '0;
`ifdef FEEDER_RELU_EN
      if (state == WAIT) result <= neu_out[N-1] ? '0 : neu_out;
`else
      if (state == WAIT) result <= neu_out;
`endif
    end
endmodule

// File: tb/tb_neuron_feeder.sv
// tb_neuron_feeder: directed checks of neuron_feeder driving a behavioural neuron_v2 model
module tb_neuron_feeder;
  logic clk, rst, w_we, x_we, b_we, start;
  logic [2:0] w_addr;
  logic signed [9:0] wr_data, result, neu_w, neu_x, neu_b, neu_out;
  logic busy, done, neu_rst, neu_inpt;
  logic signed [31:0] acc, sh;
  int n_cmp = 0, n_err = 0;
  int lat, ni, nb, extra;
  logic signed [9:0] bv;

  neuron_feeder #(.N(10), .K(8)) dut (
    .clk(clk), .rst(rst), .w_we(w_we), .x_we(x_we), .b_we(b_we), .w_addr(w_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done), .result(result),
    .neu_rst(neu_rst), .neu_inpt(neu_inpt), .neu_w(neu_w), .neu_x(neu_x), .neu_b(neu_b),
    .neu_out(neu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // neuron model: products in Q18, bias added as b<<<N, output acc>>>Q saturated to N bits
  always_ff @(posedge clk)
    if (neu_rst) acc <= 32'sd0;
    else acc <= acc + (neu_inpt ? neu_w * neu_x : 32'sd0) + (32'(neu_b) <<< 10);
  always_comb begin
    sh = acc >>> 9;
    neu_out = sh > 32'sd511 ? 10'sd511 : sh < -32'sd512 ? 10'sh200 : sh[9:0];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int wv, input int xv, input int bias);
    for (int i = 0; i < 8; i++) begin
      w_we = 1'b1; w_addr = 3'(i); wr_data = 10'(wv); tick();
    end
    w_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      x_we = 1'b1; w_addr = 3'(i); wr_data = 10'(xv); tick();
    end
    x_we = 1'b0;
    b_we = 1'b1; wr_data = 10'(bias); tick();
    b_we = 1'b0;
  endtask

  // called one cycle after start was sampled; returns cycles-to-done and stream stats
  task automatic wait_done(output int l, output int n_i, output int n_b, output logic signed [9:0] b);
    l = 1; n_i = 0; n_b = 0; b = '0;
    while (!done && l < 40) begin
      n_i += int'(neu_inpt);
      if (neu_b != 0) begin n_b++; b = neu_b; end
      tick();
      l++;
    end
  endtask

  task automatic run(output int l, output int n_i, output int n_b, output logic signed [9:0] b);
    start = 1'b1; tick(); start = 1'b0;
    wait_done(l, n_i, n_b, b);
  endtask

  initial begin
    rst = 1'b0; w_we = 1'b0; x_we = 1'b0; b_we = 1'b0; start = 1'b0; w_addr = '0; wr_data = '0;
    tick(); tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_neu_rst", int'(neu_rst), 1);
    chk("rst_neu_inpt", int'(neu_inpt), 0);
    chk("rst_neu_wxb", int'(neu_w) | int'(neu_x) | int'(neu_b), 0);
    rst = 1'b1; tick();
    chk("idle_neu_rst", int'(neu_rst), 0);

    load(64, 128, 0);
    run(lat, ni, nb, bv);
    chk("t1_latency", lat, 12);
    chk("t1_inpt_cycles", ni, 8);
    chk("t1_bias_cycles", nb, 0);
    chk("t1_result", int'(result), 128);
    chk("t1_busy_at_done", int'(busy), 0);

    load(-64, 128, 0);
    run(lat, ni, nb, bv);
`ifdef FEEDER_RELU_EN
    chk("t2_result", int'(result), 0);
`else
    chk("t2_result", int'(result), -128);
`endif

    load(0, 0, 32);
    run(lat, ni, nb, bv);
    chk("t3_result", int'(result), 64);
    chk("t3_bias_cycles", nb, 1);
    chk("t3_bias_value", int'(bv), 32);
    chk("t3_latency", lat, 12);

    load(64, 128, 0);
    run(lat, ni, nb, bv);
    chk("t4_first_result", int'(result), 128);
    start = 1'b1; w_we = 1'b1; w_addr = 3'd0; wr_data = -10'sd64; tick();
    start = 1'b0; w_we = 1'b0;
    chk("t4_b2b_busy", int'(busy), 1);
    chk("t4_b2b_clear", int'(neu_rst), 1);
    wait_done(lat, ni, nb, bv);
    chk("t4_b2b_latency", lat, 12);
    chk("t4_b2b_result", int'(result), 96);

    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; w_we = 1'b1; w_addr = 3'd1; wr_data = 10'sd0; tick();
    start = 1'b0; w_we = 1'b0;
    wait_done(lat, ni, nb, bv);
    chk("t5_done_seen", int'(done), 1);
    chk("t5_result", int'(result), 96);
    extra = 0;
    for (int i = 0; i < 20; i++) begin tick(); extra += int'(done); end
    chk("t5_extra_done", extra, 0);
    run(lat, ni, nb, bv);
    chk("t5_rerun_result", int'(result), 96);

    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t6_in_stream", int'(neu_inpt), 1);
    rst = 1'b0; #1;
    chk("t6_busy", int'(busy), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_neu_rst", int'(neu_rst), 1);
    chk("t6_result", int'(result), 0);
    extra = 0;
    for (int i = 0; i < 3; i++) begin tick(); extra += int'(done) + int'(!neu_rst); end
    chk("t6_held", extra, 0);
    rst = 1'b1; tick();
    load(64, 128, 16);
    run(lat, ni, nb, bv);
    chk("t6_rerun_latency", lat, 12);
    chk("t6_rerun_result", int'(result), 160);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
